// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - shared state type and default width for the down timer
package down_timer_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_timer_dec.sv
// rtl/down_timer_dec.sv - combinational WIDTH-bit decrementer built as a borrow chain
module down_timer_dec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_borrow;

    assign w_borrow[0] = 1'b1;

    // A bit flips while a borrow is still rippling in; the borrow dies at the first 1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_y[i] = i_a[i] ^ w_borrow[i];
        if (i < WIDTH - 1) begin : g_chain
            assign w_borrow[i+1] = w_borrow[i] & ~i_a[i];
        end
    end

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable start/stop down counter with expiry pulse; optional reload via DOWN_TIMER_RELOAD_EN
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_count_dec;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_count_zero;
    logic             w_count_one;
`ifdef DOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
`endif

    down_timer_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .i_a (r_count),
        .o_y (w_count_dec)
    );

    assign w_count_zero = (r_count == '0);
    assign w_count_one  = (r_count == WIDTH'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_count_nxt = load_val;
            w_state_nxt = IDLE;
        end else if (stop) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_count_zero) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    // RUN is never entered with zero; the guard only keeps count from wrapping.
                    if (w_count_zero) begin
                        w_state_nxt = IDLE;
                    end else if (w_count_one) begin
                        w_done_nxt = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
                        if (r_reload != '0) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = IDLE;
                        end
`else
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
`endif
                    end else begin
                        w_count_nxt = w_count_dec;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef DOWN_TIMER_RELOAD_EN
    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            r_reload <= '0;
        end else if (load) begin
            r_reload <= load_val;
        end
    end
`endif

    assign count = r_count;
    assign busy  = (r_state == RUN);
    assign done  = r_done;

endmodule
